// File: rtl/sss_ref_correlator.sv
// Sequential SSS reference RAM reader and multiply-accumulate correlator.
// Optional threshold detect on odet is built only when SSS_CORR_DET_EN is defined.
module sss_ref_correlator #(
    parameter int pDAT_W = 4,
    parameter int pSMP_W = 12,
    parameter int pLEN   = 1024,
    parameter int pACC_W = pSMP_W + pDAT_W + $clog2(pLEN)
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic              istart,
    input  logic              iabort,
    input  logic              ival,
    input  logic [pSMP_W-1:0] idat,
    input  logic [pACC_W-1:0] ithr,
    output logic              oram_val,
    output logic [10:0]       oram_addr,
    input  logic [pDAT_W-1:0] iram_dat,
    output logic              obusy,
    output logic              oval,
    output logic [pACC_W-1:0] oacc,
    output logic              odet
);

    localparam int          PROD_W = pSMP_W + pDAT_W;
    localparam int          EXT_W  = pACC_W - PROD_W;
    localparam logic [10:0] LAST   = 11'(pLEN - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t                    state;
    logic [10:0]               cnt;
    logic signed [pSMP_W-1:0]  smp_d;
    logic                      pipe_vld;
    logic signed [pACC_W-1:0]  acc;
    logic signed [PROD_W-1:0]  smp_ext;
    logic signed [PROD_W-1:0]  dat_ext;
    logic signed [PROD_W-1:0]  prod;
    logic signed [pACC_W-1:0]  prod_ext;

    // The product always fits in PROD_W bits, so the low half of the multiply is exact.
    assign smp_ext  = PROD_W'(smp_d);
    assign dat_ext  = PROD_W'($signed(iram_dat));
    assign prod     = smp_ext * dat_ext;
    assign prod_ext = {{EXT_W{prod[PROD_W-1]}}, prod};

    assign oram_val  = (state == RUN) && ival && !iabort;
    assign oram_addr = cnt;
    assign obusy     = (state == RUN) || (state == FLUSH);

`ifdef SSS_CORR_DET_EN
    // Negating the most-negative value wraps to 2^(pACC_W-1), which is its true magnitude.
    logic [pACC_W-1:0] acc_mag;
    assign acc_mag = acc[pACC_W-1] ? $unsigned(-acc) : $unsigned(acc);
`else
    logic unused_thr;
    assign unused_thr = ^ithr;
    assign odet       = 1'b0;
`endif

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state    <= IDLE;
            cnt      <= '0;
            smp_d    <= '0;
            pipe_vld <= 1'b0;
            acc      <= '0;
            oval     <= 1'b0;
            oacc     <= '0;
`ifdef SSS_CORR_DET_EN
            odet     <= 1'b0;
`endif
        end else begin
            oval     <= 1'b0;
            pipe_vld <= 1'b0;
            if (pipe_vld)
                acc <= acc + prod_ext;
            if (iabort) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (istart) begin
                            acc   <= '0;
                            cnt   <= '0;
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        if (ival) begin
                            smp_d    <= $signed(idat);
                            pipe_vld <= 1'b1;
                            if (cnt == LAST) begin
                                cnt   <= '0;
                                state <= FLUSH;
                            end else begin
                                cnt <= cnt + 11'd1;
                            end
                        end
                    end
                    // Stay until the final product has landed in acc, then publish it.
                    FLUSH: begin
                        if (!pipe_vld) begin
                            state <= DONE;
                            oval  <= 1'b1;
                            oacc  <= acc;
`ifdef SSS_CORR_DET_EN
                            odet  <= (acc_mag >= ithr);
`endif
                        end
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sss_ref_correlator.sv
// Randomized self-checking bench for sss_ref_correlator with a RAM model and sum-of-products reference.
module tb_sss_ref_correlator;

    localparam int DAT_W = 4;
    localparam int SMP_W = 12;
    localparam int LEN   = 1024;
    localparam int ACC_W = SMP_W + DAT_W + $clog2(LEN);

    logic             iclk = 1'b0;
    logic             irst;
    logic             istart;
    logic             iabort;
    logic             ival;
    logic [SMP_W-1:0] idat;
    logic [ACC_W-1:0] ithr;
    logic             oram_val;
    logic [10:0]      oram_addr;
    logic [DAT_W-1:0] iram_dat;
    logic             obusy;
    logic             oval;
    logic [ACC_W-1:0] oacc;
    logic             odet;

    sss_ref_correlator #(
        .pDAT_W(DAT_W), .pSMP_W(SMP_W), .pLEN(LEN), .pACC_W(ACC_W)
    ) dut (
        .iclk(iclk), .irst(irst), .istart(istart), .iabort(iabort), .ival(ival),
        .idat(idat), .ithr(ithr), .oram_val(oram_val), .oram_addr(oram_addr),
        .iram_dat(iram_dat), .obusy(obusy), .oval(oval), .oacc(oacc), .odet(odet)
    );

    always #5 iclk = ~iclk;

    // Reference RAM: registered read, data valid one clock after the enable.
    logic [DAT_W-1:0] ram [0:2047];
    int               smp [0:LEN-1];

    always @(posedge iclk)
        if (oram_val) iram_dat <= ram[oram_addr];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int addr_log[$];
    int last_acc_edge = 0;
    int oval_cnt = 0;
    int oval_edge = 0;
    int start_edge = 0;
    bit timed_out = 0;
    logic [ACC_W-1:0] got_acc;
    logic             got_det;
    logic [ACC_W-1:0] hold_acc = '0;
    logic             hold_det = 1'b0;

    always @(posedge iclk) cyc <= cyc + 1;

    always @(negedge iclk) begin
        if (oram_val) begin
            addr_log.push_back(int'(oram_addr));
            last_acc_edge = cyc + 1;
        end
        if (oval) begin
            oval_cnt++;
            oval_edge = cyc;
            got_acc = oacc;
            got_det = odet;
        end
    end

    function automatic longint model_sum();
        longint s = 0;
        for (int i = 0; i < LEN; i++) begin
            int r = int'(ram[i]);
            if (r > 7) r -= 16;
            s += longint'(smp[i]) * longint'(r);
        end
        return s;
    endfunction

    function automatic logic model_det(input longint s, input logic [ACC_W-1:0] thr);
`ifdef SSS_CORR_DET_EN
        longint m = (s < 0) ? -s : s;
        return (m >= longint'(thr));
`else
        return 1'b0;
`endif
    endfunction

    function automatic int sweep_errors();
        int bad = (addr_log.size() != LEN) ? 1 : 0;
        for (int i = 0; i < addr_log.size(); i++)
            if (addr_log[i] != i) bad++;
        return bad;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < LEN; i++) begin
            smp[i] = int'($urandom_range(0, 4095)) - 2048;
            ram[i] = DAT_W'($urandom);
        end
    endtask

    // Drives one run: istart, then samples with random gaps; optionally stops early or aborts.
    task automatic do_run(input int gap_max, input int stop_after, input bit do_abort, input int restart_at);
        bit seen = 0;
        addr_log.delete();
        timed_out = 0;
        @(posedge iclk); #1 istart = 1'b1;
        @(posedge iclk); #1 istart = 1'b0;
        start_edge = cyc;
        for (int i = 0; i < LEN; i++) begin
            if (i == stop_after) break;
            repeat ($urandom_range(0, gap_max)) begin
                ival = 1'b0;
                idat = SMP_W'($urandom);
                @(posedge iclk); #1;
            end
            ival   = 1'b1;
            idat   = SMP_W'(smp[i]);
            istart = (i == restart_at);
            @(posedge iclk); #1;
        end
        ival   = 1'b0;
        istart = 1'b0;
        if (stop_after < LEN) begin
            if (do_abort) begin
                iabort = 1'b1;
                @(posedge iclk); #1 iabort = 1'b0;
            end
        end else begin
            for (int k = 0; k < 20; k++) begin
                @(negedge iclk);
                if (oval) begin
                    seen = 1;
                    break;
                end
            end
            #1 timed_out = !seen;
        end
    endtask

    task automatic test_reset();
        irst = 1'b1; istart = 1'b0; iabort = 1'b0; ival = 1'b1; idat = '0; ithr = '0;
        iram_dat = '0;
        repeat (3) @(posedge iclk);
        #1;
        checks++; if (obusy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", obusy); end
        checks++; if (oval !== 1'b0) begin errors++; $display("[TB] FAIL rst_oval: got %b expected 0", oval); end
        checks++; if (oacc !== '0) begin errors++; $display("[TB] FAIL rst_oacc: got %0d expected 0", oacc); end
        checks++; if (odet !== 1'b0) begin errors++; $display("[TB] FAIL rst_odet: got %b expected 0", odet); end
        checks++; if (oram_val !== 1'b0) begin errors++; $display("[TB] FAIL rst_ram_val: got %b expected 0", oram_val); end
        checks++; if (oram_addr !== 11'd0) begin errors++; $display("[TB] FAIL rst_ram_addr: got %0d expected 0", oram_addr); end
        ival = 1'b0;
        @(posedge iclk); #2 irst = 1'b0;
        // ival alone in IDLE must not read the RAM
        ival = 1'b1;
        @(negedge iclk);
        checks++; if (oram_val !== 1'b0) begin errors++; $display("[TB] FAIL idle_ram_val: got %b expected 0", oram_val); end
        @(posedge iclk); #1 ival = 1'b0;
    endtask

    task automatic test_all_ones();
        int oc0 = oval_cnt;
        longint s;
        for (int i = 0; i < LEN; i++) begin smp[i] = 1; ram[i] = 4'b0001; end
        ithr = ACC_W'(2000);
        s = model_sum();
        do_run(0, LEN, 0, -1);
        checks++; if (timed_out) begin errors++; $display("[TB] FAIL ones_timeout: got no oval expected oval"); end
        checks++; if (got_acc !== ACC_W'(s)) begin errors++; $display("[TB] FAIL ones_acc: got %0d expected %0d", got_acc, ACC_W'(s)); end
        checks++; if (got_det !== model_det(s, ithr)) begin errors++; $display("[TB] FAIL ones_det: got %b expected %b", got_det, model_det(s, ithr)); end
        checks++; if (sweep_errors() != 0) begin errors++; $display("[TB] FAIL ones_sweep: got %0d bad addresses expected 0", sweep_errors()); end
        checks++; if (oval_edge != last_acc_edge + 2) begin errors++; $display("[TB] FAIL ones_latency: got edge %0d expected %0d", oval_edge, last_acc_edge + 2); end
        checks++; if (oval_edge + 1 - start_edge != LEN + 3) begin errors++; $display("[TB] FAIL ones_runlen: got %0d expected %0d", oval_edge + 1 - start_edge, LEN + 3); end
        checks++; if (obusy !== 1'b0) begin errors++; $display("[TB] FAIL done_busy: got %b expected 0", obusy); end
        repeat (4) @(posedge iclk);
        #1;
        checks++; if (oval_cnt - oc0 != 1) begin errors++; $display("[TB] FAIL ones_oval_count: got %0d expected 1", oval_cnt - oc0); end
        checks++; if (oacc !== ACC_W'(s)) begin errors++; $display("[TB] FAIL ones_hold: got %0d expected %0d", oacc, ACC_W'(s)); end
        hold_acc = ACC_W'(s); hold_det = model_det(s, ithr);
    endtask

    task automatic test_gaps();
        int oc0 = oval_cnt;
        longint s;
        for (int i = 0; i < LEN; i++) begin smp[i] = 5; ram[i] = (i % 2 == 0) ? 4'b0001 : 4'b1111; end
        s = model_sum();
        do_run(3, LEN, 0, -1);
        checks++; if (timed_out || oval_cnt - oc0 != 1) begin errors++; $display("[TB] FAIL gaps_oval: got %0d pulses expected 1", oval_cnt - oc0); end
        checks++; if (got_acc !== ACC_W'(s)) begin errors++; $display("[TB] FAIL gaps_acc: got %0d expected %0d", got_acc, ACC_W'(s)); end
        checks++; if (oval_edge != last_acc_edge + 2) begin errors++; $display("[TB] FAIL gaps_latency: got edge %0d expected %0d", oval_edge, last_acc_edge + 2); end
        checks++; if (sweep_errors() != 0) begin errors++; $display("[TB] FAIL gaps_sweep: got %0d bad addresses expected 0", sweep_errors()); end
        hold_acc = ACC_W'(s); hold_det = model_det(s, ithr);
    endtask

    task automatic test_threshold();
        longint s;
        for (int i = 0; i < LEN; i++) begin smp[i] = -2048; ram[i] = 4'b1111; end
        s = model_sum();
        for (int t = 0; t < 2; t++) begin
            ithr = ACC_W'(2097152 + t);
            do_run(1, LEN, 0, -1);
            checks++; if (timed_out || got_acc !== ACC_W'(s)) begin errors++; $display("[TB] FAIL thr_acc%0d: got %0d expected %0d", t, got_acc, ACC_W'(s)); end
            checks++; if (got_det !== model_det(s, ithr)) begin errors++; $display("[TB] FAIL thr_det%0d: got %b expected %b", t, got_det, model_det(s, ithr)); end
            hold_acc = ACC_W'(s); hold_det = model_det(s, ithr);
        end
    endtask

    task automatic test_abort();
        int oc0 = oval_cnt;
        longint s;
        fill_random();
        do_run(2, 500, 1, -1);
        repeat (10) @(posedge iclk);
        #1;
        checks++; if (oval_cnt != oc0) begin errors++; $display("[TB] FAIL abort_oval: got %0d pulses expected 0", oval_cnt - oc0); end
        checks++; if (obusy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", obusy); end
        checks++; if (oacc !== hold_acc || odet !== hold_det) begin errors++; $display("[TB] FAIL abort_hold: got %0d/%b expected %0d/%b", oacc, odet, hold_acc, hold_det); end
        fill_random();
        ithr = ACC_W'($urandom_range(0, 1 << 22));
        s = model_sum();
        do_run(1, LEN, 0, -1);
        checks++; if (timed_out || addr_log.size() == 0 || addr_log[0] != 0) begin errors++; $display("[TB] FAIL abort_restart_addr: got %0d expected 0", (addr_log.size() == 0) ? -1 : addr_log[0]); end
        checks++; if (got_acc !== ACC_W'(s)) begin errors++; $display("[TB] FAIL abort_restart_acc: got %0d expected %0d", got_acc, ACC_W'(s)); end
        checks++; if (got_det !== model_det(s, ithr)) begin errors++; $display("[TB] FAIL abort_restart_det: got %b expected %b", got_det, model_det(s, ithr)); end
        hold_acc = ACC_W'(s); hold_det = model_det(s, ithr);
    endtask

    task automatic test_start_ignored();
        int oc0 = oval_cnt;
        longint s;
        fill_random();
        s = model_sum();
        do_run(1, LEN, 0, 10);
        repeat (5) @(posedge iclk);
        #1;
        checks++; if (timed_out || oval_cnt - oc0 != 1) begin errors++; $display("[TB] FAIL restart_oval: got %0d pulses expected 1", oval_cnt - oc0); end
        checks++; if (got_acc !== ACC_W'(s)) begin errors++; $display("[TB] FAIL restart_acc: got %0d expected %0d", got_acc, ACC_W'(s)); end
        checks++; if (sweep_errors() != 0) begin errors++; $display("[TB] FAIL restart_sweep: got %0d bad addresses expected 0", sweep_errors()); end
        hold_acc = ACC_W'(s); hold_det = model_det(s, ithr);
    endtask

    task automatic test_back_to_back();
        longint s;
        int first_oval;
        for (int r = 0; r < 2; r++) begin
            fill_random();
            ithr = ACC_W'($urandom_range(0, 1 << 22));
            s = model_sum();
            first_oval = oval_edge;
            do_run(r * 2, LEN, 0, -1);
            if (r == 1) begin
                checks++; if (start_edge != first_oval + 2) begin errors++; $display("[TB] FAIL b2b_start: got edge %0d expected %0d", start_edge, first_oval + 2); end
            end
            checks++; if (timed_out || got_acc !== ACC_W'(s)) begin errors++; $display("[TB] FAIL b2b_acc%0d: got %0d expected %0d", r, got_acc, ACC_W'(s)); end
            checks++; if (got_det !== model_det(s, ithr)) begin errors++; $display("[TB] FAIL b2b_det%0d: got %b expected %b", r, got_det, model_det(s, ithr)); end
            hold_acc = ACC_W'(s); hold_det = model_det(s, ithr);
        end
    endtask

    task automatic test_reset_midrun();
        int oc0;
        int bad = 0;
        fill_random();
        do_run(0, 300, 0, -1);
        oc0 = oval_cnt;
        ival = 1'b1;
        idat = SMP_W'(smp[300]);
        @(posedge iclk); #2 irst = 1'b1;
        #1;
        checks++; if (obusy !== 1'b0 || oram_val !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got busy=%b ram_val=%b expected 0/0", obusy, oram_val); end
        checks++; if (oram_addr !== 11'd0) begin errors++; $display("[TB] FAIL midrst_addr: got %0d expected 0", oram_addr); end
        checks++; if (oacc !== '0 || odet !== 1'b0 || oval !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out: got %0d/%b/%b expected 0/0/0", oacc, odet, oval); end
        repeat (2) @(posedge iclk);
        #2 irst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge iclk);
            if (obusy !== 1'b0 || oram_val !== 1'b0) bad++;
        end
        ival = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL midrst_idle: got %0d busy cycles expected 0", bad); end
        checks++; if (oval_cnt != oc0) begin errors++; $display("[TB] FAIL midrst_oval: got %0d pulses expected 0", oval_cnt - oc0); end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_gaps();
        test_threshold();
        test_abort();
        test_start_ignored();
        test_back_to_back();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sss_ref_correlator.md
# sss_ref_correlator

Sequential reader and correlator for the SSS reference RAM; sits directly downstream of that RAM in the sync IP. After a start pulse it:
- walks the RAM address space one entry per valid input sample;
- multiplies each sample by the returned reference element and accumulates the products over `pLEN` samples;
- reports the final correlation value, with an optional threshold-detect flag, to the sync FSM.

## Interface
- `pDAT_W`, 4: reference element width; matches the RAM data width; signed two's complement.
- `pSMP_W`, 12: input sample width, signed.
- `pLEN`, 1024: samples per correlation, 2..2048.
- `pACC_W`, `pSMP_W+pDAT_W+$clog2(pLEN)`: accumulator and result width.

- `iclk`  in  1  sole clock, rising edge.
- `irst`  in  1  reset; asynchronous, active-high.
- `istart`  in  1  start pulse; accepted only in IDLE.
- `iabort`  in  1  abort; returns to IDLE without a result.
- `ival`  in  1  input sample valid.
- `idat`  in  `pSMP_W`  input sample, signed.
- `ithr`  in  `pACC_W`  detection threshold, unsigned magnitude.
- `oram_val`  out  1  RAM read enable; drives the RAM `ival`.
- `oram_addr`  out  11  RAM read address; drives the RAM `addr`.
- `iram_dat`  in  `pDAT_W`  RAM `odat`; valid one clock after `oram_val`.
- `obusy`  out  1  high in RUN and FLUSH.
- `oval`  out  1  one-cycle result strobe.
- `oacc`  out  `pACC_W`  correlation result, signed.
- `odet`  out  1  threshold hit, qualified by `oval`.

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
- **IDLE**
  - `istart` clears the accumulator and counter, then moves to RUN.
- **RUN**
  - `oram_val = ival`, combinational. `oram_addr` = registered counter `cnt`.
  - On each `ival`: register `idat` into the pipe stage, set the pipe-valid flag, increment `cnt`.
  - `ival` gaps are allowed. The pipe-valid flag follows `ival` each cycle.
  - When `ival` arrives with `cnt == pLEN-1`, move to FLUSH.
- **FLUSH**
  - The last product is added this cycle. `oram_val` is 0. Move to DONE.
- **DONE**
  - `oval` = 1 for this single cycle. Move to IDLE.
- **MAC**
  - On each edge where pipe-valid = 1: `acc <= acc + smp_d * $signed(iram_dat)`. Full-precision product, sign-extended to `pACC_W`, no saturation.
- **`oacc`**
  - Updated with the final `acc` on the entry edge to DONE.
  - Held until the next `oval`. The intermediate accumulator is not visible on the port.
- **`odet`**
  - Computed on the same edge as `oacc`: `|acc| >= ithr`.
  - The most-negative accumulator value is treated as magnitude `2^(pACC_W-1)`.
  - Held alongside `oacc`.
- **`iabort`**
  - In any state: next state is IDLE. Pipe-valid is cleared, `cnt` is cleared, `oval` is not pulsed, and `oacc`/`odet` keep their previous values.
  - `iabort` has priority over `istart` and `ival`.
- **`istart` outside IDLE** is ignored.
- **`ival` in IDLE, FLUSH or DONE** is ignored: no RAM read, no MAC.
- **`irst`**: state IDLE, `cnt` 0, `acc` 0, pipe-valid 0, `oval` 0, `oacc` 0, `odet` 0, `obusy` 0, `oram_val` 0, `oram_addr` 0.
  - Reset mid-run discards the run with no result.

## Timing
- Sample accepted on edge N: the RAM registers `iram_dat` on edge N; the product is accumulated on edge N+1.
- Last sample accepted on edge L:
  - `obusy` stays high through FLUSH;
  - DONE is entered on edge L+2;
  - `oval` is high during the cycle following edge L+2 and low again after edge L+3.
- Minimum run length is `pLEN` + 3 clocks from the `istart` edge to the `oval` drop.
- A new `istart` is accepted in the cycle after DONE, i.e. back-to-back runs are allowed.
- `oram_addr` never exceeds `pLEN-1`. No wrap inside a run; the counter resets per run.

## Configuration
- `SSS_CORR_DET_EN`
  - **Defined**: the magnitude compare and `odet` register are built as described.
  - **Undefined**: no compare logic; `odet` is tied to 0 and `ithr` is unused. All other behaviour is identical.

## Test plan
- `pLEN`=1024, RAM all `4'b0001`, `idat`=1 on every cycle, one `istart` -> `oval` once, `oacc`=1024, `oram_addr` sweeps 0..1023 exactly once.
- RAM alternating +1/-1, `idat`=5 constant, `ival` with random 0–3 cycle gaps -> `oacc`=0. No MAC on gap cycles; `oval` exactly 2 edges after the last accepted sample edge.
- RAM all `4'b1111` (-1), `idat`=-2048, `ithr`=2097152 -> `oacc`=2097152 and `odet`=1. Rerun with `ithr`=2097153 -> `odet`=0. Rerun with the macro undefined -> `odet`=0 in both cases.
- `iabort` after 500 samples, then `istart` -> no `oval` for the aborted run; the new run starts at `oram_addr` 0 and produces the correct full sum.
- `istart` pulsed at sample 10 of a run -> ignored; a single `oval` occurs after 1024 samples.
- `irst` asserted mid-run, asynchronously between edges -> all outputs 0 immediately; after release, `obusy`=0 until `istart`.
